ts_flow_occupancy_ctrl: RTL
===========================

Name: ts_flow_occupancy_ctrl

Overview:
Per-flow occupancy controller for the 32 TS injection flows. It counts buffered TS packets per flow as packets are enqueued into, and released from, the injection buffer. From those counts it drives the 32-bit per-flow overflow vector consumed by the TS overflow monitor on its iv_ts_cnt input. It sits beside the packet map/dispatch path, between the enqueue side (monitor accept) and the injection scheduler (release).

Parameters:
FLOW_NUM, 32, number of TS flows (flow id width = 5; fixed at 32 in this revision)
CNT_W, 4, width of each per-flow occupancy counter

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_enq_pulse  input  1  one-cycle pulse: one TS packet of flow iv_enq_flow buffered
iv_enq_flow  input  5  flow id for enqueue
i_deq_pulse  input  1  one-cycle pulse: one TS packet of flow iv_deq_flow released
iv_deq_flow  input  5  flow id for dequeue
iv_threshold  input  CNT_W  per-flow overflow threshold (static config, sampled every cycle)
i_flow_clr  input  1  one-cycle pulse: force count of iv_clr_flow to 0
iv_clr_flow  input  5  flow id to clear
ov_ts_cnt  output  32  bit f = 1 when flow f is at/above threshold (overflow, block new packets)
o_underflow_pulse  output  1  one-cycle pulse: dequeue seen on a flow with count 0
ov_underflow_flow  output  5  flow id of the last underflow
o_saturate_pulse  output  1  one-cycle pulse: enqueue seen on a flow with count at max (2^CNT_W-1)
iv_rd_flow  input  5  debug read flow id
ov_rd_cnt  output  CNT_W  count of iv_rd_flow, registered
ov_total_cnt  output  10  sum of all flow counts (running total)

Behaviour:
- Reset (async, i_rst_n=0): all 32 counters = 0; ov_ts_cnt = 32'h0; o_underflow_pulse = 0; ov_underflow_flow = 0; o_saturate_pulse = 0; ov_rd_cnt = 0; ov_total_cnt = 0. Reset mid-operation discards all counts immediately.
- Counter update per cycle, applied on the clock edge after the pulse:
  - Enqueue only on flow f: cnt[f]+1. If cnt[f] is at max, cnt[f] stays at max, o_saturate_pulse = 1 next cycle, and ov_total_cnt is unchanged.
  - Dequeue only on flow f: cnt[f]-1. If cnt[f] = 0, cnt[f] stays 0, o_underflow_pulse = 1 next cycle, ov_underflow_flow = f, and ov_total_cnt is unchanged.
  - Enqueue and dequeue on the same flow in the same cycle: net 0. No saturate or underflow is flagged, even at count 0 or max.
  - Enqueue and dequeue on different flows in the same cycle: both applied independently, each with its own saturate/underflow rule.
  - i_flow_clr on flow f: cnt[f] = 0 and has priority over enqueue/dequeue on f in that cycle. ov_total_cnt drops by the old cnt[f], plus any enqueue/dequeue applied to other flows in the same cycle. No error pulses are raised for f that cycle.
- ov_ts_cnt[f] is registered as (next cnt[f] >= iv_threshold), evaluated on the post-update count. The flag therefore asserts the cycle after the enqueue that reaches the threshold and deasserts the cycle after the dequeue that drops below it.
- iv_threshold = 0: every bit of ov_ts_cnt is 1, i.e. all TS flows are blocked. A threshold change takes effect within 1 cycle for all flows.
- ov_rd_cnt = cnt[iv_rd_flow] registered: 1-cycle latency, showing the post-update value of the previous cycle.
- ov_total_cnt tracks exactly the sum of the counters. Width 10 holds 32 × 15 = 480, so it never wraps.
- Error pulses last exactly 1 cycle. ov_underflow_flow holds its value until the next underflow.
- No state machine beyond the counter array. All outputs are registered, and no output is combinational from inputs.

Test Plan:
1. After reset, threshold = 3; 3 enqueue pulses on flow 5 -> ov_ts_cnt = 32'h0000_0020 one cycle after the 3rd pulse; ov_rd_cnt (rd_flow = 5) = 3; ov_total_cnt = 3.
2. From test 1, 1 dequeue on flow 5 -> ov_ts_cnt[5] = 0 next cycle; count = 2. Then 3 more dequeues -> the 3rd gives o_underflow_pulse = 1 for 1 cycle, ov_underflow_flow = 5, count stays 0.
3. Flow 31 at count 15; simultaneous enqueue and dequeue on flow 31 -> count stays 15, no saturate pulse. Then enqueue alone -> o_saturate_pulse = 1, count 15, ov_total_cnt unchanged.
4. Same cycle: enqueue flow 2, dequeue flow 7 (count 4), clear flow 9 (count 6) -> next cycle counts 1 / 3 / 0; ov_total_cnt decreases by 6.
5. Clear and enqueue on flow 0 in the same cycle with count 5 -> count 0, ov_ts_cnt[0] = 0 (threshold 3), no pulses.
6. Threshold set to 0 -> ov_ts_cnt = 32'hFFFF_FFFF the next cycle. Assert i_rst_n low mid-stream -> all outputs 0 immediately; counts restart from 0.

Source files
------------

// File: rtl/ts_flow_occupancy_ctrl.sv
// Per-flow TS packet occupancy counters. They drive the registered per-flow
// overflow vector, the underflow/saturate error pulses, a debug read port and a running total.
module ts_flow_occupancy_ctrl #(
    parameter int unsigned FLOW_NUM = 32,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_enq_pulse,
    input  logic [$clog2(FLOW_NUM)-1:0] iv_enq_flow,
    input  logic                        i_deq_pulse,
    input  logic [$clog2(FLOW_NUM)-1:0] iv_deq_flow,
    input  logic [CNT_W-1:0]            iv_threshold,
    input  logic                        i_flow_clr,
    input  logic [$clog2(FLOW_NUM)-1:0] iv_clr_flow,
    output logic [FLOW_NUM-1:0]         ov_ts_cnt,
    output logic                        o_underflow_pulse,
    output logic [$clog2(FLOW_NUM)-1:0] ov_underflow_flow,
    output logic                        o_saturate_pulse,
    input  logic [$clog2(FLOW_NUM)-1:0] iv_rd_flow,
    output logic [CNT_W-1:0]            ov_rd_cnt,
    output logic [9:0]                  ov_total_cnt
);

    localparam int unsigned FID_W = $clog2(FLOW_NUM);
    localparam int unsigned TOT_W = 10;

    logic [CNT_W-1:0]    r_cnt     [FLOW_NUM];
    logic [CNT_W-1:0]    w_cnt_nxt [FLOW_NUM];
    logic [FLOW_NUM-1:0] w_flag_nxt;
    logic [TOT_W-1:0]    w_total_nxt;
    logic                w_same;
    logic                w_enq_act;
    logic                w_deq_act;
    logic                w_sat;
    logic                w_uf;
    logic                w_inc;
    logic                w_dec;

    // Enqueue/dequeue are first reduced to at most one increment and one
    // decrement on distinct flows; the clear then overrides its own flow.
    always_comb begin
        w_same    = i_enq_pulse && i_deq_pulse && (iv_enq_flow == iv_deq_flow);
        w_enq_act = i_enq_pulse && !w_same && !(i_flow_clr && (iv_clr_flow == iv_enq_flow));
        w_deq_act = i_deq_pulse && !w_same && !(i_flow_clr && (iv_clr_flow == iv_deq_flow));
        w_sat     = w_enq_act && (r_cnt[iv_enq_flow] == '1);
        w_uf      = w_deq_act && (r_cnt[iv_deq_flow] == '0);
        w_inc     = w_enq_act && !w_sat;
        w_dec     = w_deq_act && !w_uf;

        for (int unsigned f = 0; f < FLOW_NUM; f++) begin
            w_cnt_nxt[f] = r_cnt[f];
            if (w_inc && (iv_enq_flow == FID_W'(f)))
                w_cnt_nxt[f] = r_cnt[f] + 1'b1;
            if (w_dec && (iv_deq_flow == FID_W'(f)))
                w_cnt_nxt[f] = r_cnt[f] - 1'b1;
            if (i_flow_clr && (iv_clr_flow == FID_W'(f)))
                w_cnt_nxt[f] = '0;
            w_flag_nxt[f] = (w_cnt_nxt[f] >= iv_threshold);
        end

        w_total_nxt = ov_total_cnt + TOT_W'(w_inc) - TOT_W'(w_dec);
        if (i_flow_clr)
            w_total_nxt = w_total_nxt - TOT_W'(r_cnt[iv_clr_flow]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned f = 0; f < FLOW_NUM; f++)
                r_cnt[f] <= '0;
            ov_ts_cnt         <= '0;
            o_underflow_pulse <= 1'b0;
            ov_underflow_flow <= '0;
            o_saturate_pulse  <= 1'b0;
            ov_rd_cnt         <= '0;
            ov_total_cnt      <= '0;
        end else begin
            for (int unsigned f = 0; f < FLOW_NUM; f++)
                r_cnt[f] <= w_cnt_nxt[f];
            ov_ts_cnt         <= w_flag_nxt;
            o_underflow_pulse <= w_uf;
            o_saturate_pulse  <= w_sat;
            if (w_uf)
                ov_underflow_flow <= iv_deq_flow;
            ov_rd_cnt         <= w_cnt_nxt[iv_rd_flow];
            ov_total_cnt      <= w_total_nxt;
        end
    end

endmodule
